seg_scan_mux: RTL and testbench

SEG_SCAN_MUX -- requirements
Module: seg_scan_mux

---
 rtl/seg_scan_mux.sv | 160 ++++++++++++++++
 tb/tb_seg_scan_mux.sv | 212 +++++++++++++++++++++
 2 files changed

// File: rtl/seg_scan_mux.sv
// Three-digit common-anode scan multiplexer: tens (BCD-decoded), ones and tenths
// digits, each slot opening with a dark blanking window, plus a frame-done pulse.
module seg_scan_mux #(
    parameter int SCAN_DIV        = 50000,
    parameter int BLANK_CYC       = 500,
    parameter bit TENS_ZERO_BLANK = 1'b1
) (
    input  logic       clk_50M,
    input  logic       rst,
    input  logic       disp_en,
    input  logic [3:0] tens,
    input  logic [6:0] out_ge,
    input  logic [6:0] out_xiao,
    input  logic       point,
    output logic [2:0] dig_sel,
    output logic [6:0] seg,
    output logic       dp,
    output logic       frame_done
);

    localparam int             CW       = $clog2(SCAN_DIV);
    localparam logic [CW-1:0]  CNT_LAST = CW'(SCAN_DIV - 1);
    localparam logic [CW-1:0]  CAP_CNT  = CW'(BLANK_CYC - 1);
    localparam logic [CW-1:0]  SHOW_CNT = CW'(BLANK_CYC);

    typedef enum logic {PH_BLANK, PH_SHOW} phase_t;
    typedef enum logic [1:0] {
        DIG_TENS   = 2'd0,
        DIG_ONES   = 2'd1,
        DIG_TENTHS = 2'd2
    } dig_t;

    logic [CW-1:0] r_cnt;
    dig_t          r_idx;
    logic [3:0]    r_snap_tens;
    logic [6:0]    r_snap_ge;
    logic [6:0]    r_snap_xiao;
    logic          r_snap_point;
    logic          r_frame_pend;
    logic [2:0]    r_dig_sel;
    logic [6:0]    r_seg;
    logic          r_dp;
    logic          r_frame_done;

    logic          w_slot_end;
    logic          w_frame_end;
    logic          w_capture;
    phase_t        w_phase;
    logic [2:0]    w_dig_sel_n;
    logic [6:0]    w_seg_n;
    logic          w_dp_n;

    // Active-high {a,b,c,d,e,f,g}; anything above 9 renders as a lone dash.
    function automatic logic [6:0] bcd_to_seg(input logic [3:0] v);
        case (v)
            4'd0:    bcd_to_seg = 7'h7E;
            4'd1:    bcd_to_seg = 7'h30;
            4'd2:    bcd_to_seg = 7'h6D;
            4'd3:    bcd_to_seg = 7'h79;
            4'd4:    bcd_to_seg = 7'h33;
            4'd5:    bcd_to_seg = 7'h5B;
            4'd6:    bcd_to_seg = 7'h5F;
            4'd7:    bcd_to_seg = 7'h70;
            4'd8:    bcd_to_seg = 7'h7F;
            4'd9:    bcd_to_seg = 7'h7B;
            default: bcd_to_seg = 7'h01;
        endcase
    endfunction

    assign w_slot_end  = (r_cnt == CNT_LAST);
    assign w_frame_end = w_slot_end && (r_idx == DIG_TENTHS);
    // Latch the inputs on the last dark cycle of the tens slot so a whole frame
    // shows one consistent value.
    assign w_capture   = (r_idx == DIG_TENS) && (r_cnt == CAP_CNT);
    assign w_phase     = (r_cnt < SHOW_CNT) ? PH_BLANK : PH_SHOW;

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of block ordering.
    always_ff @(posedge clk_50M) begin
        if (rst) begin
            r_cnt <= '0;
            r_idx <= DIG_TENS;
        end else if (w_slot_end) begin
            r_cnt <= '0;
            case (r_idx)
                DIG_TENS:   r_idx <= DIG_ONES;
                DIG_ONES:   r_idx <= DIG_TENTHS;
                default:    r_idx <= DIG_TENS;
            endcase
        end else begin
            r_cnt <= r_cnt + CW'(1);
        end
    end

    always_ff @(posedge clk_50M) begin
        if (rst) begin
            r_snap_tens  <= '0;
            r_snap_ge    <= '0;
            r_snap_xiao  <= '0;
            r_snap_point <= 1'b0;
        end else if (w_capture) begin
            r_snap_tens  <= tens;
            r_snap_ge    <= out_ge;
            r_snap_xiao  <= out_xiao;
            r_snap_point <= point;
        end
    end

    // NOTE: every output of this block gets a default first, so no path can
    // leave a value held and infer a latch.
    always_comb begin
        w_dig_sel_n = 3'b111;
        w_seg_n     = 7'h7F;
        w_dp_n      = 1'b1;
        if (disp_en && (w_phase == PH_SHOW)) begin
            case (r_idx)
                DIG_TENS: begin
                    if (!(TENS_ZERO_BLANK && (r_snap_tens == 4'd0))) begin
                        w_dig_sel_n = 3'b110;
                        w_seg_n     = ~bcd_to_seg(r_snap_tens);
                    end
                end
                DIG_ONES: begin
                    w_dig_sel_n = 3'b101;
                    w_seg_n     = ~r_snap_ge;
                    w_dp_n      = ~r_snap_point;
                end
                DIG_TENTHS: begin
                    w_dig_sel_n = 3'b011;
                    w_seg_n     = ~r_snap_xiao;
                end
                default: ;
            endcase
        end
    end

    // frame_done is delayed one extra stage so it marks the first cycle of the
    // new frame, matching the one-cycle output latency of the digit drive.
    always_ff @(posedge clk_50M) begin
        if (rst) begin
            r_dig_sel    <= 3'b111;
            r_seg        <= 7'h7F;
            r_dp         <= 1'b1;
            r_frame_pend <= 1'b0;
            r_frame_done <= 1'b0;
        end else begin
            r_dig_sel    <= w_dig_sel_n;
            r_seg        <= w_seg_n;
            r_dp         <= w_dp_n;
            r_frame_pend <= w_frame_end;
            r_frame_done <= r_frame_pend;
        end
    end

    assign dig_sel    = r_dig_sel;
    assign seg        = r_seg;
    assign dp         = r_dp;
    assign frame_done = r_frame_done;

endmodule

// File: tb/tb_seg_scan_mux.sv
// Directed-then-random bench for seg_scan_mux; expectations come from a
// time-since-reset model of the scan schedule with its own frame snapshot.
module tb_seg_scan_mux;

    localparam int SD  = 10;
    localparam int BC  = 2;
    localparam bit TZB = 1'b1;
    localparam int FRAME = 3 * SD;

    logic       clk = 1'b0;
    logic       rst;
    logic       disp_en;
    logic [3:0] tens;
    logic [6:0] out_ge;
    logic [6:0] out_xiao;
    logic       point;
    logic [2:0] dig_sel;
    logic [6:0] seg;
    logic       dp;
    logic       frame_done;

    int total = 0;
    int bad   = 0;

    // Model state: edges since reset release, plus the values the frame shows.
    int         t;
    logic [3:0] m_tens;
    logic [6:0] m_ge;
    logic [6:0] m_xiao;
    logic       m_point;

    logic [6:0] seg_tab [0:9] = '{7'h7E, 7'h30, 7'h6D, 7'h79, 7'h33,
                                  7'h5B, 7'h5F, 7'h70, 7'h7F, 7'h7B};

    seg_scan_mux #(.SCAN_DIV(SD), .BLANK_CYC(BC), .TENS_ZERO_BLANK(TZB)) dut (
        .clk_50M    (clk),
        .rst        (rst),
        .disp_en    (disp_en),
        .tens       (tens),
        .out_ge     (out_ge),
        .out_xiao   (out_xiao),
        .point      (point),
        .dig_sel    (dig_sel),
        .seg        (seg),
        .dp         (dp),
        .frame_done (frame_done)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h (t=%0d)", tag, obs, exp, t);
        end
    endtask

    // One clock edge: predict outputs from pre-edge model state, advance the
    // model, then compare after the edge.
    task automatic step();
        logic [2:0] e_ds;
        logic [6:0] e_sg;
        logic       e_dp;
        logic       e_fd;
        int         pos;
        int         dig;
        e_ds = 3'b111;
        e_sg = 7'h7F;
        e_dp = 1'b1;
        e_fd = 1'b0;
        pos  = t % SD;
        dig  = (t / SD) % 3;
        if (!rst) begin
            e_fd = (t != 0) && (t % FRAME == 0);
            if (disp_en && pos >= BC) begin
                if (dig == 0) begin
                    if (!(TZB && m_tens == 4'd0)) begin
                        e_ds = 3'b110;
                        e_sg = ~((m_tens <= 4'd9) ? seg_tab[int'(m_tens)] : 7'h01);
                    end
                end else if (dig == 1) begin
                    e_ds = 3'b101;
                    e_sg = ~m_ge;
                    e_dp = ~m_point;
                end else begin
                    e_ds = 3'b011;
                    e_sg = ~m_xiao;
                end
            end
        end
        if (rst) begin
            t       = 0;
            m_tens  = '0;
            m_ge    = '0;
            m_xiao  = '0;
            m_point = 1'b0;
        end else begin
            if (dig == 0 && pos == BC - 1) begin
                m_tens  = tens;
                m_ge    = out_ge;
                m_xiao  = out_xiao;
                m_point = point;
            end
            t++;
        end
        @(posedge clk);
        #1;
        check("dig_sel",    {5'd0, dig_sel},    {5'd0, e_ds});
        check("seg",        {1'b0, seg},        {1'b0, e_sg});
        check("dp",         {7'd0, dp},         {7'd0, e_dp});
        check("frame_done", {7'd0, frame_done}, {7'd0, e_fd});
    endtask

    // Step until the next edge will sample the given position within a frame.
    task automatic run_to(input int frame_pos);
        for (int i = 0; i < FRAME && (t % FRAME) != frame_pos; i++) step();
    endtask

    task automatic expect_const(input string tag, input logic [2:0] ds, input logic [6:0] sg,
                                input logic d, input logic fd);
        check({tag, ".dig_sel"},    {5'd0, dig_sel},    {5'd0, ds});
        check({tag, ".seg"},        {1'b0, seg},        {1'b0, sg});
        check({tag, ".dp"},         {7'd0, dp},         {7'd0, d});
        check({tag, ".frame_done"}, {7'd0, frame_done}, {7'd0, fd});
    endtask

    initial begin
        t        = 0;
        m_tens   = '0;
        m_ge     = '0;
        m_xiao   = '0;
        m_point  = 1'b0;
        rst      = 1'b1;
        disp_en  = 1'b1;
        tens     = 4'd5;
        out_ge   = 7'h7E;
        out_xiao = 7'h30;
        point    = 1'b1;

        // Reset state.
        repeat (3) step();
        expect_const("reset", 3'b111, 7'h7F, 1'b1, 1'b0);

        // Basic frame: all-off blanking, then tens 5, ones 0 with point, tenths 1.
        rst = 1'b0;
        repeat (2) step();
        expect_const("blank0", 3'b111, 7'h7F, 1'b1, 1'b0);
        repeat (3) step();
        expect_const("tens5", 3'b110, 7'h24, 1'b1, 1'b0);
        repeat (8) step();
        expect_const("ones", 3'b101, 7'h01, 1'b0, 1'b0);
        repeat (10) step();
        expect_const("tenths", 3'b011, 7'h4F, 1'b1, 1'b0);
        repeat (8) step();
        expect_const("frame1", 3'b111, 7'h7F, 1'b1, 1'b1);
        step();
        expect_const("frame1_end", 3'b111, 7'h7F, 1'b1, 1'b0);
        repeat (FRAME - 1) step();
        check("frame2_pulse", {7'd0, frame_done}, 8'd1);

        // Zero-blanked tens, then out-of-range tens as a dash.
        tens = 4'd0;
        run_to(BC + 3);
        repeat (FRAME) step();
        tens = 4'd12;
        run_to(BC + 3);
        repeat (FRAME) step();
        check("tens12_dash", {1'b0, seg}, {1'b0, 7'b1111110});

        // Changing the ones input mid-slot must not tear the current frame.
        tens = 4'd7;
        run_to(SD + BC + 2);
        out_ge = 7'h30;
        point  = 1'b0;
        repeat (2 * FRAME) step();

        // Display disabled for five cycles in the middle of a SHOW window.
        run_to(2 * SD + 4);
        disp_en = 1'b0;
        repeat (5) step();
        disp_en = 1'b1;
        repeat (FRAME) step();

        // One-cycle reset during the tenths slot.
        run_to(2 * SD + 5);
        rst = 1'b1;
        step();
        expect_const("mid_reset", 3'b111, 7'h7F, 1'b1, 1'b0);
        rst = 1'b0;
        repeat (FRAME + 2) step();

        // Randomized inputs, enable and occasional resets.
        for (int i = 0; i < 900; i++) begin
            if ($urandom_range(3) == 0) begin
                tens     = 4'($urandom_range(15));
                out_ge   = 7'($urandom);
                out_xiao = 7'($urandom);
                point    = 1'($urandom);
            end
            disp_en = ($urandom_range(7) != 0);
            rst     = ($urandom_range(199) == 0);
            step();
        end
        rst = 1'b0;
        repeat (FRAME) step();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
